// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward-mux selects,
// FSM states and scoreboard field widths.
package hazard_unit_pkg;

    // Same select encoding as the decode stage's operand forward mux.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int SB_VALID_BITS  = 1;
    localparam int SB_LOAD_BITS   = 1;
    localparam int STALL_CNT_BITS = 2;
    localparam int WAIT_CNT_BITS  = 8;

    // Source register fields inside instr_top (instruction bits [31:16]).
    localparam int FIELD_BITS = 5;
    localparam int RS_LSB     = 5;
    localparam int RT_LSB     = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority match of one source register against the EX/MEM/WB scoreboard;
// the youngest in-flight writer wins and register 0 never forwards.
module hazard_fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0] src,
    input  logic                ex_valid,
    input  logic [REG_BITS-1:0] ex_dst,
    input  logic                mem_valid,
    input  logic [REG_BITS-1:0] mem_dst,
    input  logic                wb_valid,
    input  logic [REG_BITS-1:0] wb_dst,
    output fwd_sel_t            sel
);

    always_comb begin
        // NOTE: default assigned first so every path drives sel and no latch is inferred.
        sel = FWD_REG;
        if (src != '0) begin
            if (ex_valid && ex_dst == src) begin
                sel = FWD_EX;
            end else if (mem_valid && mem_dst == src) begin
                sel = FWD_MEM;
            end else if (wb_valid && wb_dst == src) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller: private EX/MEM/WB writer scoreboard,
// forward selects, load-use stall, memory-wait freeze and branch/jump flushes.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_BITS          = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int WAIT_LIMIT        = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instr_top,
    input  logic [REG_BITS-1:0] id_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                jump_taken,
    input  logic                branch_taken,
    input  logic                mem_busy,
    output logic [1:0]          ctrl_rs,
    output logic [1:0]          ctrl_rt,
    output logic                if_we,
    output logic                id_we,
    output logic                if_flush,
    output logic                id_flush,
    output logic                ex_flush,
    output logic                wait_timeout
);

    typedef struct packed {
        logic [SB_VALID_BITS-1:0] valid;
        logic [REG_BITS-1:0]      dst;
        logic [SB_LOAD_BITS-1:0]  is_load;
    } sb_entry_t;

    localparam sb_entry_t                 SB_BUBBLE  = '0;
    localparam logic [STALL_CNT_BITS-1:0] STALL_INIT = STALL_CNT_BITS'(LOAD_STALL_CYCLES - 1);
    localparam logic [WAIT_CNT_BITS-1:0]  WAIT_MAX   = WAIT_CNT_BITS'(WAIT_LIMIT);

    state_t                    state, state_nx;
    sb_entry_t                 sb_ex, sb_mem, sb_wb;
    sb_entry_t                 sb_ex_nx, sb_mem_nx, sb_wb_nx;
    sb_entry_t                 id_entry;
    logic [STALL_CNT_BITS-1:0] stall_cnt, stall_cnt_nx;
    logic [WAIT_CNT_BITS-1:0]  wait_cnt, wait_cnt_nx;
    logic [REG_BITS-1:0]       rs, rt;
    logic                      load_use;
    logic                      flushing;
    fwd_sel_t                  rs_sel, rt_sel;
    logic                      unused_bits;

    assign rs       = REG_BITS'(instr_top[RS_LSB +: FIELD_BITS]);
    assign rt       = REG_BITS'(instr_top[RT_LSB +: FIELD_BITS]);
    assign id_entry = '{valid: id_reg_write, dst: id_dst, is_load: id_mem_read};

    // rt is compared for every opcode, even ones that do not read it.
    assign load_use = sb_ex.valid[0] && sb_ex.is_load[0] && (sb_ex.dst != '0)
                   && (sb_ex.dst == rs || sb_ex.dst == rt);

    // The opcode and the oldest entry's load flag take no part in any decision.
    assign unused_bits = ^{instr_top[15:10], sb_wb.is_load};

    hazard_fwd_sel #(.REG_BITS(REG_BITS)) u_fwd_rs (
        .src      (rs),
        .ex_valid (sb_ex.valid[0]),
        .ex_dst   (sb_ex.dst),
        .mem_valid(sb_mem.valid[0]),
        .mem_dst  (sb_mem.dst),
        .wb_valid (sb_wb.valid[0]),
        .wb_dst   (sb_wb.dst),
        .sel      (rs_sel)
    );

    hazard_fwd_sel #(.REG_BITS(REG_BITS)) u_fwd_rt (
        .src      (rt),
        .ex_valid (sb_ex.valid[0]),
        .ex_dst   (sb_ex.dst),
        .mem_valid(sb_mem.valid[0]),
        .mem_dst  (sb_mem.dst),
        .wb_valid (sb_wb.valid[0]),
        .wb_dst   (sb_wb.dst),
        .sel      (rt_sel)
    );

    assign flushing = if_flush | id_flush | ex_flush;
    assign ctrl_rs  = flushing ? FWD_REG : rs_sel;
    assign ctrl_rt  = flushing ? FWD_REG : rt_sel;

    // Events are tested in priority order; a WAIT with mem_busy low behaves as RUN.
    always_comb begin
        state_nx     = state;
        stall_cnt_nx = stall_cnt;
        wait_cnt_nx  = wait_cnt;
        sb_ex_nx     = sb_ex;
        sb_mem_nx    = sb_mem;
        sb_wb_nx     = sb_wb;
        if_we        = 1'b0;
        id_we        = 1'b0;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        ex_flush     = 1'b0;

        if (mem_busy) begin
            state_nx     = WAIT;
            stall_cnt_nx = '0;
            if (state != WAIT) begin
                wait_cnt_nx = WAIT_CNT_BITS'(1);
            end else if (wait_cnt < WAIT_MAX) begin
                wait_cnt_nx = wait_cnt + 1'b1;
            end
        end else if (branch_taken) begin
            if_we        = 1'b1;
            if_flush     = 1'b1;
            id_flush     = 1'b1;
            ex_flush     = 1'b1;
            sb_ex_nx     = SB_BUBBLE;
            sb_mem_nx    = SB_BUBBLE;
            sb_wb_nx     = sb_mem;
            state_nx     = RUN;
            stall_cnt_nx = '0;
        end else if (state == STALL) begin
            id_flush     = 1'b1;
            sb_ex_nx     = SB_BUBBLE;
            sb_mem_nx    = sb_ex;
            sb_wb_nx     = sb_mem;
            stall_cnt_nx = stall_cnt - 1'b1;
            if (stall_cnt <= STALL_CNT_BITS'(1)) begin
                state_nx = RUN;
            end
        end else if (jump_taken) begin
            if_we     = 1'b1;
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            sb_ex_nx  = SB_BUBBLE;
            sb_mem_nx = sb_ex;
            sb_wb_nx  = sb_mem;
            state_nx  = RUN;
        end else if (load_use) begin
            id_we     = 1'b1;
            id_flush  = 1'b1;
            sb_ex_nx  = SB_BUBBLE;
            sb_mem_nx = sb_ex;
            sb_wb_nx  = sb_mem;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nx     = STALL;
                stall_cnt_nx = STALL_INIT;
            end else begin
                state_nx = RUN;
            end
        end else begin
            if_we     = 1'b1;
            id_we     = 1'b1;
            sb_ex_nx  = id_entry;
            sb_mem_nx = sb_ex;
            sb_wb_nx  = sb_mem;
            state_nx  = RUN;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state        <= RUN;
            sb_ex        <= SB_BUBBLE;
            sb_mem       <= SB_BUBBLE;
            sb_wb        <= SB_BUBBLE;
            stall_cnt    <= '0;
            wait_cnt     <= '0;
            wait_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            sb_ex     <= sb_ex_nx;
            sb_mem    <= sb_mem_nx;
            sb_wb     <= sb_wb_nx;
            stall_cnt <= stall_cnt_nx;
            wait_cnt  <= wait_cnt_nx;
            if (wait_cnt_nx == WAIT_MAX) begin
                wait_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: three hazard_unit configurations driven in lockstep and
// compared every cycle against an event-table model of in-flight writers.
module tb_hazard_unit;

    localparam int NI = 3;
    localparam int LSC[NI]  = '{1, 2, 3};
    localparam int WLIM[NI] = '{255, 3, 8};

    localparam int EV_BUSY   = 0;
    localparam int EV_BR     = 1;
    localparam int EV_BUBBLE = 2;
    localparam int EV_JMP    = 3;
    localparam int EV_LU     = 4;
    localparam int EV_ADV    = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_top;
    logic [4:0]  id_dst;
    logic        id_reg_write, id_mem_read, jump_taken, branch_taken, mem_busy;

    logic [1:0] o_ctrl_rs[NI];
    logic [1:0] o_ctrl_rt[NI];
    logic       o_if_we[NI], o_id_we[NI], o_if_flush[NI], o_id_flush[NI], o_ex_flush[NI], o_to[NI];

    int n_pass  = 0;
    int n_total = 0;

    // Model: per instance, the three youngest writers (age 0 = in EX), bubbles
    // still owed, whether the previous cycle was a memory wait, and its length.
    bit m_v[NI][3];
    int m_d[NI][3];
    bit m_ld[NI][3];
    int m_owed[NI];
    bit m_wait[NI];
    int m_wcnt[NI];
    bit m_to[NI];

    always #5 clk = ~clk;

    hazard_unit #(.REG_BITS(5), .LOAD_STALL_CYCLES(1), .WAIT_LIMIT(255)) dut_a (
        .clk(clk), .reset(reset), .instr_top(instr_top), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .jump_taken(jump_taken),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .ctrl_rs(o_ctrl_rs[0]), .ctrl_rt(o_ctrl_rt[0]), .if_we(o_if_we[0]), .id_we(o_id_we[0]),
        .if_flush(o_if_flush[0]), .id_flush(o_id_flush[0]), .ex_flush(o_ex_flush[0]),
        .wait_timeout(o_to[0])
    );

    hazard_unit #(.REG_BITS(5), .LOAD_STALL_CYCLES(2), .WAIT_LIMIT(3)) dut_b (
        .clk(clk), .reset(reset), .instr_top(instr_top), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .jump_taken(jump_taken),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .ctrl_rs(o_ctrl_rs[1]), .ctrl_rt(o_ctrl_rt[1]), .if_we(o_if_we[1]), .id_we(o_id_we[1]),
        .if_flush(o_if_flush[1]), .id_flush(o_id_flush[1]), .ex_flush(o_ex_flush[1]),
        .wait_timeout(o_to[1])
    );

    hazard_unit #(.REG_BITS(5), .LOAD_STALL_CYCLES(3), .WAIT_LIMIT(8)) dut_c (
        .clk(clk), .reset(reset), .instr_top(instr_top), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .jump_taken(jump_taken),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .ctrl_rs(o_ctrl_rs[2]), .ctrl_rt(o_ctrl_rt[2]), .if_we(o_if_we[2]), .id_we(o_id_we[2]),
        .if_flush(o_if_flush[2]), .id_flush(o_id_flush[2]), .ex_flush(o_ex_flush[2]),
        .wait_timeout(o_to[2])
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int fwd_of(input int i, input int src);
        if (src == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (m_v[i][k] && m_d[i][k] == src) return k + 1;
        return 0;
    endfunction

    task automatic model_reset(input int i);
        for (int k = 0; k < 3; k++) begin
            m_v[i][k] = 0; m_d[i][k] = 0; m_ld[i][k] = 0;
        end
        m_owed[i] = 0; m_wait[i] = 0; m_wcnt[i] = 0; m_to[i] = 0;
    endtask

    task automatic model_step(input int i);
        int  rs_i, rt_i, ev;
        bit  lu, e_ifwe, e_idwe, e_iff, e_idf, e_exf;
        int  e_rs, e_rt;
        rs_i = int'(instr_top[9:5]);
        rt_i = int'(instr_top[4:0]);
        lu = m_v[i][0] && m_ld[i][0] && m_d[i][0] != 0 && (m_d[i][0] == rs_i || m_d[i][0] == rt_i);
        if (mem_busy)          ev = EV_BUSY;
        else if (branch_taken) ev = EV_BR;
        else if (m_owed[i] > 0) ev = EV_BUBBLE;
        else if (jump_taken)   ev = EV_JMP;
        else if (lu)           ev = EV_LU;
        else                   ev = EV_ADV;

        e_ifwe = (ev == EV_BR || ev == EV_JMP || ev == EV_ADV);
        e_idwe = (ev == EV_LU || ev == EV_ADV);
        e_iff  = (ev == EV_BR || ev == EV_JMP);
        e_idf  = (ev == EV_BR || ev == EV_JMP || ev == EV_LU || ev == EV_BUBBLE);
        e_exf  = (ev == EV_BR);
        e_rs   = (e_iff || e_idf || e_exf) ? 0 : fwd_of(i, rs_i);
        e_rt   = (e_iff || e_idf || e_exf) ? 0 : fwd_of(i, rt_i);

        check($sformatf("i%0d if_we", i),        int'(o_if_we[i]),    int'(e_ifwe));
        check($sformatf("i%0d id_we", i),        int'(o_id_we[i]),    int'(e_idwe));
        check($sformatf("i%0d if_flush", i),     int'(o_if_flush[i]), int'(e_iff));
        check($sformatf("i%0d id_flush", i),     int'(o_id_flush[i]), int'(e_idf));
        check($sformatf("i%0d ex_flush", i),     int'(o_ex_flush[i]), int'(e_exf));
        check($sformatf("i%0d ctrl_rs", i),      int'(o_ctrl_rs[i]),  e_rs);
        check($sformatf("i%0d ctrl_rt", i),      int'(o_ctrl_rt[i]),  e_rt);
        check($sformatf("i%0d wait_timeout", i), int'(o_to[i]),       int'(m_to[i]));

        case (ev)
            EV_BUSY: begin
                m_wcnt[i] = m_wait[i] ? ((m_wcnt[i] + 1 > WLIM[i]) ? WLIM[i] : m_wcnt[i] + 1) : 1;
                if (m_wcnt[i] >= WLIM[i]) m_to[i] = 1;
                m_owed[i] = 0;
            end
            EV_BR: begin
                m_v[i][2] = m_v[i][1]; m_d[i][2] = m_d[i][1]; m_ld[i][2] = m_ld[i][1];
                m_v[i][1] = 0; m_v[i][0] = 0;
                m_owed[i] = 0;
            end
            default: begin
                for (int k = 2; k > 0; k--) begin
                    m_v[i][k] = m_v[i][k-1]; m_d[i][k] = m_d[i][k-1]; m_ld[i][k] = m_ld[i][k-1];
                end
                m_v[i][0]  = (ev == EV_ADV) ? id_reg_write : 1'b0;
                m_d[i][0]  = int'(id_dst);
                m_ld[i][0] = id_mem_read;
                if (ev == EV_LU)     m_owed[i] = LSC[i] - 1;
                if (ev == EV_BUBBLE) m_owed[i] = m_owed[i] - 1;
            end
        endcase
        m_wait[i] = (ev == EV_BUSY);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) model_reset(i);
            else       model_step(i);
        end
    end

    // One cycle of stimulus; returns just after the following falling edge.
    task automatic drive(input int rs, input int rt, input int dst, input bit rw, input bit mr,
                         input bit j, input bit b, input bit busy, input bit rst);
        @(posedge clk);
        #1;
        reset        = rst;
        instr_top    = {6'h00, 5'(rs), 5'(rt)};
        id_dst       = 5'(dst);
        id_reg_write = rw;
        id_mem_read  = mr;
        jump_taken   = j;
        branch_taken = b;
        mem_busy     = busy;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int busy_run;
        reset = 1'b1; instr_top = '0; id_dst = '0; id_reg_write = 0; id_mem_read = 0;
        jump_taken = 0; branch_taken = 0; mem_busy = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Forward distance: add $3, then readers of $3 one, two, three, four cycles later.
        drive(0, 0, 3, 1, 0, 0, 0, 0, 0);
        check("reset if_we", int'(o_if_we[0]), 1);
        check("reset id_we", int'(o_id_we[0]), 1);
        check("reset ctrl_rs", int'(o_ctrl_rs[0]), 0);
        check("reset timeout", int'(o_to[1]), 0);
        drive(3, 0, 0, 0, 0, 0, 0, 0, 0); check("fwd ex", int'(o_ctrl_rs[0]), 1);
        drive(3, 0, 0, 0, 0, 0, 0, 0, 0); check("fwd mem", int'(o_ctrl_rs[0]), 2);
        drive(3, 0, 0, 0, 0, 0, 0, 0, 0); check("fwd wb", int'(o_ctrl_rs[0]), 3);
        drive(3, 0, 0, 0, 0, 0, 0, 0, 0); check("fwd none", int'(o_ctrl_rs[0]), 0);
        idle(3);

        // Load-use: lw $5 then add rt=$5.
        drive(0, 0, 5, 1, 1, 0, 0, 0, 0);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 0);
        check("lu if_we", int'(o_if_we[0]), 0);
        check("lu id_we", int'(o_id_we[0]), 1);
        check("lu id_flush", int'(o_id_flush[0]), 1);
        check("lu ctrl_rt", int'(o_ctrl_rt[0]), 0);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 0);
        check("lu1 after ctrl_rt", int'(o_ctrl_rt[0]), 2);
        check("lu2 stall if_we", int'(o_if_we[1]), 0);
        check("lu2 stall id_flush", int'(o_id_flush[1]), 1);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 0);
        check("lu2 after ctrl_rt", int'(o_ctrl_rt[1]), 3);
        check("lu2 after if_we", int'(o_if_we[1]), 1);
        idle(4);

        // Register 0 never forwards and never stalls.
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("r0 if_we", int'(o_if_we[0]), 1);
        check("r0 id_flush", int'(o_id_flush[0]), 0);
        check("r0 ctrl_rs", int'(o_ctrl_rs[0]), 0);
        check("r0 ctrl_rt", int'(o_ctrl_rt[0]), 0);
        idle(3);

        // Branch kills $7 sitting in EX; jump flushes IF/ID only.
        drive(0, 0, 7, 1, 0, 0, 0, 0, 0);
        drive(7, 0, 0, 0, 0, 0, 1, 0, 0);
        check("br if_flush", int'(o_if_flush[0]), 1);
        check("br id_flush", int'(o_id_flush[0]), 1);
        check("br ex_flush", int'(o_ex_flush[0]), 1);
        check("br if_we", int'(o_if_we[0]), 1);
        check("br ctrl_rs", int'(o_ctrl_rs[0]), 0);
        drive(7, 0, 0, 0, 0, 0, 0, 0, 0);
        check("br killed fwd", int'(o_ctrl_rs[0]), 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("jmp if_flush", int'(o_if_flush[0]), 1);
        check("jmp ex_flush", int'(o_ex_flush[0]), 0);
        check("jmp if_we", int'(o_if_we[0]), 1);
        check("jmp id_we", int'(o_id_we[0]), 0);
        idle(3);

        // mem_busy held 4 cycles during a 2-cycle load-use stall, WAIT_LIMIT=3.
        drive(0, 0, 5, 1, 1, 0, 0, 0, 0);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 0);
        drive(0, 5, 9, 1, 0, 0, 0, 1, 0);
        check("wait if_we", int'(o_if_we[1]), 0);
        check("wait id_we", int'(o_id_we[1]), 0);
        check("wait id_flush", int'(o_id_flush[1]), 0);
        check("wait ctrl_rt", int'(o_ctrl_rt[1]), 2);
        drive(0, 5, 9, 1, 0, 0, 0, 1, 0);
        check("wait frozen ctrl_rt", int'(o_ctrl_rt[1]), 2);
        drive(0, 5, 9, 1, 0, 0, 0, 1, 0);
        check("wait timeout early", int'(o_to[1]), 0);
        drive(0, 5, 9, 1, 0, 0, 0, 1, 0);
        check("wait timeout set", int'(o_to[1]), 1);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 0);
        check("wait exit if_we", int'(o_if_we[1]), 1);
        check("wait exit ctrl_rt", int'(o_ctrl_rt[1]), 2);
        idle(3);
        check("timeout sticky", int'(o_to[1]), 1);
        check("timeout big limit", int'(o_to[0]), 0);

        // Reset in the middle of a stall.
        drive(0, 0, 5, 1, 1, 0, 0, 0, 0);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 0);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 1);
        drive(0, 5, 9, 1, 0, 0, 0, 0, 0);
        check("rst stall if_we", int'(o_if_we[1]), 1);
        check("rst stall id_we", int'(o_id_we[1]), 1);
        check("rst stall ctrl_rt", int'(o_ctrl_rt[1]), 0);
        check("rst stall timeout", int'(o_to[1]), 0);

        // Randomized traffic; the negedge process checks every cycle.
        busy_run = 0;
        for (int n = 0; n < 2500; n++) begin
            bit busy;
            if (busy_run == 0 && $urandom_range(0, 79) == 0) busy_run = $urandom_range(3, 12);
            busy = (busy_run > 0) || ($urandom_range(0, 9) == 0);
            if (busy_run > 0) busy_run--;
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, busy,
                  $urandom_range(0, 249) == 0);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
